// File: rtl/chirp_sweep_gen.sv
// Linear-FM sawtooth chirp generator: a phase accumulator whose tuning word ramps from
// F_START toward F_STOP by RATE on every divided tick.
module chirp_sweep_gen (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       cfg_valid,
  input  logic [1:0] cfg_addr,
  input  logic [7:0] cfg_data,
  output logic       cfg_ready,
  output logic       busy,
  output logic       done,
  output logic       sample_valid,
  output logic [7:0] sample
);

  typedef enum logic {StIdle, StRun} state_t;

  state_t      r_state;
  logic [7:0]  r_f_start_hi;
  logic [7:0]  r_f_stop_hi;
  logic [7:0]  r_rate;
  logic [7:0]  r_div;
  logic [15:0] r_ftw;
  logic [15:0] r_phase;
  logic [7:0]  r_cnt;
  logic [7:0]  r_sample;
  logic        r_sample_valid;
  logic        r_done;

  logic [15:0] w_f_start;
  logic [15:0] w_f_stop;
  logic [15:0] w_phase_nxt;
  logic [16:0] w_ftw_sum;
  logic [15:0] w_ftw_nxt;
  logic        w_tick;
  logic        w_last;

  assign w_f_start   = {r_f_start_hi, 8'h00};
  assign w_f_stop    = {r_f_stop_hi, 8'h00};
  assign w_phase_nxt = r_phase + r_ftw;
  // 17-bit sum so the clamp against F_STOP can never be fooled by a wrap
  assign w_ftw_sum   = {1'b0, r_ftw} + {9'b0, r_rate};
  assign w_ftw_nxt   = (w_ftw_sum >= {1'b0, w_f_stop}) ? w_f_stop : w_ftw_sum[15:0];
  // stop in the same cycle cancels the tick, so no sample or done leaks out of an abort
  assign w_tick      = (r_state == StRun) && !stop && (r_cnt == r_div);
  assign w_last      = (r_ftw >= w_f_stop);

  assign cfg_ready    = (r_state == StIdle);
  assign busy         = (r_state == StRun);
  assign done         = r_done;
  assign sample_valid = r_sample_valid;
  assign sample       = r_sample;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= StIdle;
      r_f_start_hi   <= 8'h10;
      r_f_stop_hi    <= 8'h80;
      r_rate         <= 8'h01;
      r_div          <= 8'h00;
      r_ftw          <= 16'h0000;
      r_phase        <= 16'h0000;
      r_cnt          <= 8'h00;
      r_sample       <= 8'h00;
      r_sample_valid <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_sample_valid <= 1'b0;
      r_done         <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (cfg_valid) begin
            unique case (cfg_addr)
              2'd0: r_f_start_hi <= cfg_data;
              2'd1: r_f_stop_hi  <= cfg_data;
              2'd2: r_rate       <= cfg_data;
              2'd3: r_div        <= cfg_data;
              default: ;
            endcase
          end
          if (start && !stop) begin
            r_state <= StRun;
            r_ftw   <= w_f_start;
            r_phase <= 16'h0000;
            r_cnt   <= 8'h00;
          end
        end
        StRun: begin
          if (stop) begin
            r_state <= StIdle;
          end else if (w_tick) begin
            r_cnt          <= 8'h00;
            r_phase        <= w_phase_nxt;
            r_sample       <= w_phase_nxt[15:8];
            r_sample_valid <= 1'b1;
            r_ftw          <= w_ftw_nxt;
            if (w_last) begin
              r_state <= StIdle;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_chirp_sweep_gen.sv
// Directed bench for chirp_sweep_gen: timing and sample values against hand-computed vectors.
module tb_chirp_sweep_gen;

  logic       clk = 1'b0;
  logic       rst, start, stop, cfg_valid;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data;
  logic       cfg_ready, busy, done, sample_valid;
  logic [7:0] sample;

  int n_cmp = 0;
  int n_err = 0;

  chirp_sweep_gen dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .cfg_ready(cfg_ready), .busy(busy), .done(done),
    .sample_valid(sample_valid), .sample(sample)
  );

  always #5 clk = ~clk;

  // Outputs are read 1 time unit after the edge; inputs are changed at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d;
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got=%b want=0", sample_valid); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got=%b want=0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got=%b want=0", busy); end
    n_cmp++; if (sample !== 8'h00) begin n_err++; $display("FAIL rst_sample got=%h want=00", sample); end
    rst = 1'b0;
    step();
    n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL rst_cfg_ready got=%b want=1", cfg_ready); end
    // reset beats start and a cfg write in the same cycle
    rst = 1'b1; start = 1'b1; cfg_valid = 1'b1; cfg_addr = 2'd0; cfg_data = 8'h55;
    step();
    rst = 1'b0; start = 1'b0; cfg_valid = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_prio_busy got=%b want=0", busy); end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    n_cmp++; if (sample_valid !== 1'b1 || sample !== 8'h10) begin
      n_err++; $display("FAIL rst_prio_fstart got=%b/%h want=1/10", sample_valid, sample);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_prio_stop got=%b want=0", busy); end
  endtask

  task automatic test_basic();
    logic [7:0] exp_s [3];
    exp_s = '{8'h10, 8'h20, 8'h31};
    cfg_write(2'd0, 8'h10); cfg_write(2'd1, 8'h11); cfg_write(2'd2, 8'h80); cfg_write(2'd3, 8'h00);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      n_cmp++; if (busy !== (c <= 3)) begin n_err++; $display("FAIL basic_busy c=%0d got=%b", c, busy); end
      n_cmp++; if (sample_valid !== (c >= 2 && c <= 4)) begin
        n_err++; $display("FAIL basic_valid c=%0d got=%b", c, sample_valid);
      end
      n_cmp++; if (done !== (c == 4)) begin n_err++; $display("FAIL basic_done c=%0d got=%b", c, done); end
      if (c >= 2 && c <= 4) begin
        n_cmp++; if (sample !== exp_s[c-2]) begin
          n_err++; $display("FAIL basic_sample c=%0d got=%h want=%h", c, sample, exp_s[c-2]);
        end
      end
      step();
    end
    n_cmp++; if (sample !== 8'h31) begin n_err++; $display("FAIL basic_hold got=%h want=31", sample); end
  endtask

  task automatic test_divider();
    logic [7:0] exp_s [3];
    exp_s = '{8'h10, 8'h20, 8'h31};
    cfg_write(2'd3, 8'h02);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      logic ev;
      ev = (c == 4 || c == 7 || c == 10);
      n_cmp++; if (busy !== (c <= 9)) begin n_err++; $display("FAIL div_busy c=%0d got=%b", c, busy); end
      n_cmp++; if (sample_valid !== ev) begin n_err++; $display("FAIL div_valid c=%0d got=%b want=%b", c, sample_valid, ev); end
      n_cmp++; if (done !== (c == 10)) begin n_err++; $display("FAIL div_done c=%0d got=%b", c, done); end
      if (ev) begin
        n_cmp++; if (sample !== exp_s[(c-4)/3]) begin
          n_err++; $display("FAIL div_sample c=%0d got=%h want=%h", c, sample, exp_s[(c-4)/3]);
        end
      end
      step();
    end
  endtask

  task automatic test_degenerate();
    cfg_write(2'd1, 8'h08); cfg_write(2'd3, 8'h00);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      n_cmp++; if (busy !== (c == 1)) begin n_err++; $display("FAIL degen_busy c=%0d got=%b", c, busy); end
      n_cmp++; if (sample_valid !== (c == 2)) begin n_err++; $display("FAIL degen_valid c=%0d got=%b", c, sample_valid); end
      n_cmp++; if (done !== (c == 2)) begin n_err++; $display("FAIL degen_done c=%0d got=%b", c, done); end
      step();
    end
    n_cmp++; if (sample !== 8'h10) begin n_err++; $display("FAIL degen_sample got=%h want=10", sample); end
  endtask

  task automatic test_abort();
    cfg_write(2'd1, 8'h11); cfg_write(2'd2, 8'h00);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      logic [7:0] es;
      es = 8'((c - 1) * 16);
      n_cmp++; if (sample_valid !== (c >= 2)) begin n_err++; $display("FAIL abort_valid c=%0d got=%b", c, sample_valid); end
      if (c >= 2) begin
        n_cmp++; if (sample !== es) begin n_err++; $display("FAIL abort_sample c=%0d got=%h want=%h", c, sample, es); end
      end
      if (c < 6) step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b want=0", busy); end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL abort_cfg_ready got=%b want=1", cfg_ready); end
    for (int c = 0; c < 4; c++) begin
      n_cmp++; if (sample_valid !== 1'b0 || done !== 1'b0) begin
        n_err++; $display("FAIL abort_quiet c=%0d got valid=%b done=%b want 0/0", c, sample_valid, done);
      end
      step();
    end
    n_cmp++; if (sample !== 8'h50) begin n_err++; $display("FAIL abort_hold got=%h want=50", sample); end
  endtask

  task automatic test_lockout();
    logic [7:0] got [8];
    int n;
    logic seen;
    cfg_write(2'd2, 8'h80);
    start = 1'b1;
    step();
    start = 1'b0;
    n_cmp++; if (cfg_ready !== 1'b0) begin n_err++; $display("FAIL lock_cfg_ready got=%b want=0", cfg_ready); end
    cfg_valid = 1'b1; cfg_addr = 2'd2; cfg_data = 8'h40;
    step();
    cfg_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      seen = done;
      step();
    end
    n_cmp++; if (!seen) begin n_err++; $display("FAIL lock_first_done got=timeout want=done"); end
    start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      if (sample_valid === 1'b1 && n < 8) begin got[n] = sample; n++; end
      step();
    end
    n_cmp++; if (n != 3) begin n_err++; $display("FAIL lock_count got=%0d want=3", n); end
    else begin
      n_cmp++; if (got[0] !== 8'h10 || got[1] !== 8'h20 || got[2] !== 8'h31) begin
        n_err++; $display("FAIL lock_samples got=%h %h %h want=10 20 31", got[0], got[1], got[2]);
      end
    end
  endtask

  task automatic test_start_stop_idle();
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    n_cmp++; if (busy !== 1'b0 || cfg_ready !== 1'b1) begin
      n_err++; $display("FAIL ss_idle got busy=%b ready=%b want 0/1", busy, cfg_ready);
    end
    step();
    n_cmp++; if (sample_valid !== 1'b0) begin n_err++; $display("FAIL ss_valid got=%b want=0", sample_valid); end
  endtask

  task automatic test_reset_mid_sweep();
    logic [7:0] exp_s [4];
    exp_s = '{8'h10, 8'h20, 8'h30, 8'h40};
    cfg_write(2'd0, 8'h20); cfg_write(2'd1, 8'h40); cfg_write(2'd2, 8'h10);
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL mid_pre_busy got=%b want=1", busy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if (busy !== 1'b0 || sample_valid !== 1'b0 || done !== 1'b0 || sample !== 8'h00) begin
      n_err++; $display("FAIL mid_after_rst got busy=%b valid=%b done=%b sample=%h want 0/0/0/00",
                        busy, sample_valid, done, sample);
    end
    n_cmp++; if (cfg_ready !== 1'b1) begin n_err++; $display("FAIL mid_cfg_ready got=%b want=1", cfg_ready); end
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      n_cmp++; if (busy !== 1'b1 || done !== 1'b0) begin
        n_err++; $display("FAIL mid_run c=%0d got busy=%b done=%b want 1/0", c, busy, done);
      end
      n_cmp++; if (sample_valid !== (c >= 2)) begin n_err++; $display("FAIL mid_valid c=%0d got=%b", c, sample_valid); end
      if (c >= 2) begin
        n_cmp++; if (sample !== exp_s[c-2]) begin
          n_err++; $display("FAIL mid_sample c=%0d got=%h want=%h", c, sample, exp_s[c-2]);
        end
      end
      step();
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0;
    cfg_valid = 1'b0; cfg_addr = 2'd0; cfg_data = 8'h00;
    test_reset();
    test_basic();
    test_divider();
    test_degenerate();
    test_abort();
    test_lockout();
    test_start_stop_idle();
    test_reset_mid_sweep();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
